// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_pkg : shared types and defaults for the memory arbiter   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 64;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_port_arbiter_if : fetch, data and memory-side port bundle    |
// | Revision            : 1.0                                        |
// +------------------------------------------------------------------+
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_kill;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_done;
    logic [31:0] d_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_rvalid, if_rdata, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               stall_if, stall_mem, bus_err
    );

    modport master (
        output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_rvalid, if_rdata, d_done, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               stall_if, stall_mem, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arb_timeout.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_arb_timeout : per-transaction cycle counter with expiry flag |
// | Revision        : 1.0                                            |
// +------------------------------------------------------------------+
module mem_arb_timeout
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // Expiry fires during the TIMEOUT_CYC-th enabled cycle.
    assign expired_o = en_i && (count_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (en_i && !expired_o) begin
            count_q <= count_q + ONE_CNT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and data |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_e  state_q;
    arb_owner_e  owner_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        mem_req_q;
    logic        if_rvalid_q;
    logic        d_done_q;
    logic        discard_q;
    logic        discard_d;
    logic        bus_err_q;

    logic w_idle, w_busy, w_accept_data, w_accept_fetch, w_accept;
    logic w_kill_fetch, w_store_done, w_read_done, w_abort, w_finish;
    logic w_tmo_expired;

    assign w_idle         = (state_q == ST_IDLE);
    assign w_busy         = !w_idle;
    assign w_accept_data  = w_idle && bus.d_req;
    assign w_accept_fetch = w_idle && bus.if_req && !bus.if_kill && !bus.d_req;
    assign w_accept       = w_accept_data || w_accept_fetch;

    // A kill in the completing cycle must already suppress the pulse.
    assign w_kill_fetch = w_busy && (owner_q == OWN_FETCH) && bus.if_kill;
    assign discard_d    = discard_q || w_kill_fetch;

    assign w_store_done = (state_q == ST_REQ) && bus.mem_gnt && we_q;
    assign w_read_done  = (state_q == ST_RESP) && bus.mem_rvalid;
    assign w_abort      = w_tmo_expired && !((state_q == ST_REQ) && bus.mem_gnt) && !w_read_done;
    assign w_finish     = w_store_done || w_read_done || w_abort;

    mem_arb_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (w_accept),
        .en_i      (w_busy),
        .expired_o (w_tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_FETCH;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            discard_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_done_q    <= 1'b0;
            discard_q   <= discard_d;
            bus_err_q   <= bus_err_q || w_abort;
            if (w_finish) begin
                state_q     <= ST_IDLE;
                mem_req_q   <= 1'b0;
                discard_q   <= 1'b0;
                d_done_q    <= (owner_q == OWN_DATA);
                if_rvalid_q <= (owner_q == OWN_FETCH) && !discard_d;
                if (w_abort) begin
                    rdata_q <= '0;
                end else if (w_read_done) begin
                    rdata_q <= bus.mem_rdata;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_accept) begin
                            state_q   <= ST_REQ;
                            mem_req_q <= 1'b1;
                            discard_q <= 1'b0;
                            if (w_accept_data) begin
                                owner_q <= OWN_DATA;
                                addr_q  <= bus.d_addr;
                                we_q    <= bus.d_we;
                                wdata_q <= bus.d_wdata;
                                be_q    <= bus.d_be;
                            end else begin
                                owner_q <= OWN_FETCH;
                                addr_q  <= bus.if_addr;
                                we_q    <= 1'b0;
                                wdata_q <= '0;
                                be_q    <= 4'hF;
                            end
                        end
                    end
                    ST_REQ: begin
                        if (bus.mem_gnt) begin
                            state_q   <= ST_RESP;
                            mem_req_q <= 1'b0;
                        end
                    end
                    ST_RESP: begin
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = rdata_q;
    assign bus.d_done    = d_done_q;
    assign bus.d_rdata   = rdata_q;
    assign bus.bus_err   = bus_err_q;
    assign bus.stall_if  = bus.if_req && !if_rvalid_q;
    assign bus.stall_mem = bus.d_req && !d_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench               |
// | Revision            : 1.0                                        |
// +------------------------------------------------------------------+
module tb_mem_port_arbiter;

    localparam int TMO = 64;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
        checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL rst_if_rvalid: got %b expected 0", bus.if_rvalid); end
        checks++; if (bus.d_done !== 1'b0) begin errors++; $display("FAIL rst_d_done: got %b expected 0", bus.d_done); end
        checks++; if (bus.bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b expected 0", bus.bus_err); end
        checks++; if (bus.if_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.if_rdata); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
        checks++; if ({bus.stall_if, bus.stall_mem} !== 2'b00) begin errors++; $display("FAIL rst_stalls: got %b expected 00", {bus.stall_if, bus.stall_mem}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fetch_read();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        #1;
        checks++; if (bus.stall_if !== 1'b1) begin errors++; $display("FAIL fr_stall_if: got %b expected 1", bus.stall_if); end
        tick();
        checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h0000_0040}) begin errors++; $display("FAIL fr_mem_req: got %b/%b/%h expected 1/0/00000040", bus.mem_req, bus.mem_we, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        checks++; if ({bus.mem_req, bus.if_rvalid} !== 2'b00) begin errors++; $display("FAIL fr_resp_state: got req/rvalid %b expected 00", {bus.mem_req, bus.if_rvalid}); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.if_rvalid !== 1'b1) begin errors++; $display("FAIL fr_if_rvalid: got %b expected 1", bus.if_rvalid); end
        checks++; if (bus.if_rdata !== 32'h0000_0013) begin errors++; $display("FAIL fr_if_rdata: got %h expected 00000013", bus.if_rdata); end
        checks++; if (bus.stall_if !== 1'b0) begin errors++; $display("FAIL fr_stall_release: got %b expected 0", bus.stall_if); end
        bus.if_req = 1'b0;
        tick();
        checks++; if ({bus.if_rvalid, bus.mem_req} !== 2'b00) begin errors++; $display("FAIL fr_one_cycle: got rvalid/req %b expected 00", {bus.if_rvalid, bus.mem_req}); end
    endtask

    task automatic test_priority();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0080;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_1000; bus.d_be = 4'hF;
        tick();
        checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_1000}) begin errors++; $display("FAIL pri_data_first: got %b/%h expected 1/00001000", bus.mem_req, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL pri_d_done: got %b/%h expected 1/deadbeef", bus.d_done, bus.d_rdata); end
        checks++; if ({bus.if_rvalid, bus.stall_if, bus.stall_mem} !== 3'b010) begin errors++; $display("FAIL pri_stalls: got rv/sif/smem %b expected 010", {bus.if_rvalid, bus.stall_if, bus.stall_mem}); end
        bus.d_req = 1'b0;
        tick();
        checks++; if ({bus.mem_req, bus.mem_addr, bus.d_done} !== {1'b1, 32'h0000_0080, 1'b0}) begin errors++; $display("FAIL pri_fetch_second: got %b/%h/%b expected 1/00000080/0", bus.mem_req, bus.mem_addr, bus.d_done); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0011;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h0000_0011}) begin errors++; $display("FAIL pri_fetch_done: got %b/%h expected 1/00000011", bus.if_rvalid, bus.if_rdata); end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_store_wait();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_2000;
        bus.d_wdata = 32'hA5A5_A5A5; bus.d_be = 4'hF;
        tick();
        bus.d_wdata = 32'h0; bus.d_be = 4'h0;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 4'hF}) begin errors++; $display("FAIL st_stable[%0d]: got %b/%b/%h/%h/%h expected 1/1/00002000/a5a5a5a5/f", i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be); end
            bus.mem_rvalid = (i == 2);
            tick();
        end
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.mem_req, bus.d_done, bus.stall_mem} !== 3'b101) begin errors++; $display("FAIL st_still_waiting: got req/done/stall %b expected 101", {bus.mem_req, bus.d_done, bus.stall_mem}); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        checks++; if ({bus.d_done, bus.mem_req, bus.stall_mem} !== 3'b100) begin errors++; $display("FAIL st_d_done: got done/req/stall %b expected 100", {bus.d_done, bus.mem_req, bus.stall_mem}); end
        bus.d_req = 1'b0;
        bus.mem_rvalid = 1'b1;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.d_done, bus.if_rvalid, bus.mem_req} !== 3'b000) begin errors++; $display("FAIL st_no_resp: got done/rvalid/req %b expected 000", {bus.d_done, bus.if_rvalid, bus.mem_req}); end
        bus.d_we = 1'b0;
    endtask

    task automatic test_kill();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        tick();
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.if_kill = 1'b1; bus.if_req = 1'b0;
        tick();
        bus.if_kill = 1'b0;
        checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL kill_pre: got %b expected 0", bus.if_rvalid); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0055;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.if_rvalid, bus.mem_req} !== 2'b00) begin errors++; $display("FAIL kill_suppressed: got rvalid/req %b expected 00", {bus.if_rvalid, bus.mem_req}); end
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
        tick();
        checks++; if ({bus.if_rvalid, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h0000_0200}) begin errors++; $display("FAIL kill_next_fetch: got %b/%b/%h expected 0/1/00000200", bus.if_rvalid, bus.mem_req, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0066;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.if_rvalid, bus.if_rdata} !== {1'b1, 32'h0000_0066}) begin errors++; $display("FAIL kill_next_done: got %b/%h expected 1/00000066", bus.if_rvalid, bus.if_rdata); end
        bus.if_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_4000; bus.d_be = 4'hF;
        tick();
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'hCAFE_0001}) begin errors++; $display("FAIL b2b_first: got %b/%h expected 1/cafe0001", bus.d_done, bus.d_rdata); end
        bus.d_addr = 32'h0000_5000;
        tick();
        checks++; if ({bus.d_done, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h0000_5000}) begin errors++; $display("FAIL b2b_accept: got %b/%b/%h expected 0/1/00005000", bus.d_done, bus.mem_req, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0002;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.d_done, bus.d_rdata} !== {1'b1, 32'hCAFE_0002}) begin errors++; $display("FAIL b2b_second: got %b/%h expected 1/cafe0002", bus.d_done, bus.d_rdata); end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int   n          = 0;
        logic done       = 1'b0;
        logic err_before = 1'bx;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_3000; bus.d_be = 4'hF;
        while (!done && n < 4 * TMO) begin
            bus.if_kill = (n == 10);
            tick();
            n++;
            if (bus.d_done) done = 1'b1;
            else if (n == TMO) err_before = bus.bus_err;
        end
        bus.if_kill = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL tmo_pulse_seen: got %b expected 1 within %0d cycles", done, 4 * TMO); end
        checks++; if (n !== TMO + 1) begin errors++; $display("FAIL tmo_latency: got %0d expected %0d", n, TMO + 1); end
        checks++; if (err_before !== 1'b0) begin errors++; $display("FAIL tmo_err_early: got %b expected 0", err_before); end
        checks++; if ({bus.bus_err, bus.d_rdata, bus.mem_req, bus.if_rvalid} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL tmo_abort: got err/rdata/req/rv %b/%h/%b/%b expected 1/00000000/0/0", bus.bus_err, bus.d_rdata, bus.mem_req, bus.if_rvalid); end
        bus.d_req = 1'b0;
        tick();
        tick();
        checks++; if ({bus.d_done, bus.bus_err, bus.mem_req} !== 3'b010) begin errors++; $display("FAIL tmo_sticky: got done/err/req %b expected 010", {bus.d_done, bus.bus_err, bus.mem_req}); end
    endtask

    task automatic test_reset_mid();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
        tick();
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        reset = 1'b1; bus.if_req = 1'b0;
        tick();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.if_rvalid, bus.d_done, bus.mem_req, bus.bus_err} !== 4'b0000) begin errors++; $display("FAIL rmid_flags: got rv/done/req/err %b expected 0000", {bus.if_rvalid, bus.d_done, bus.mem_req, bus.bus_err}); end
        checks++; if ({bus.if_rdata, bus.mem_addr} !== 64'h0) begin errors++; $display("FAIL rmid_data: got rdata/addr %h/%h expected 0/0", bus.if_rdata, bus.mem_addr); end
        tick();
        checks++; if ({bus.if_rvalid, bus.mem_req} !== 2'b00) begin errors++; $display("FAIL rmid_late: got rv/req %b expected 00", {bus.if_rvalid, bus.mem_req}); end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_priority();
        test_store_wait();
        test_kill();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: max cycles one transaction may wait for mem_gnt plus mem_rvalid before abort.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 if_req  in  1  fetch request, held high until if_rvalid; if_addr  in  32  fetch address.
REQ-005 if_kill  in  1  fetch flush (ifid_flush); discards the fetch in flight.
REQ-006 if_rvalid  out  1  one-cycle fetch completion; if_rdata  out  32  fetched word.
REQ-007 d_req  in  1  data request, held until d_done; d_we  in  1  store; d_addr  in  32; d_wdata  in  32; d_be  in  4  byte enables.
REQ-008 d_done  out  1  one-cycle data completion; d_rdata  out  32  load data.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32; mem_be  out  4  single shared memory port request.
REQ-010 mem_gnt  in  1  memory accepted request; mem_rvalid  in  1  read data valid; mem_rdata  in  32.
REQ-011 stall_if  out  1; stall_mem  out  1  pipeline stalls to hazard logic; bus_err  out  1  sticky timeout flag.

Function
REQ-012 FSM states IDLE, REQ, RESP; one outstanding transaction at most.
REQ-013 IDLE: d_req wins over if_req (older instruction first); fetch accepted only if if_req && !if_kill && !d_req.
REQ-014 On acceptance, owner, addr, we, wdata, be captured into registers; next cycle state REQ with mem_req=1 driving captured values.
REQ-015 Request fields on mem_* SHALL stay stable while mem_req=1 and mem_gnt=0.
REQ-016 REQ + mem_gnt: store -> IDLE, d_done pulses next cycle; read -> RESP, mem_req drops.
REQ-017 RESP + mem_rvalid: mem_rdata captured, owner's valid/done pulses exactly one cycle later with captured data, state -> IDLE.
REQ-018 Minimum read latency: request cycle 0, mem_req cycle 1 with gnt, rvalid cycle 2, completion pulse cycle 3.
REQ-019 if_kill while fetch owns REQ/RESP sets discard flag; transaction completes on memory side, if_rvalid suppressed; flag cleared on completion.
REQ-020 if_kill with no fetch in flight has no effect; never affects data transactions.
REQ-021 stall_if = if_req && !if_rvalid; stall_mem = d_req && !d_done (combinational).
REQ-022 Timeout counter clears on acceptance, increments each cycle in REQ/RESP; on reaching TIMEOUT_CYC: abort, bus_err set, owner pulse with rdata 0 (suppressed if discarded), state -> IDLE.
REQ-023 mem_rvalid while IDLE or REQ ignored; mem_gnt outside REQ ignored.
REQ-024 New acceptance in IDLE on the cycle the completion pulse is driven is allowed (back-to-back).

Reset
REQ-025 Reset: state IDLE, all outputs 0, counter 0, discard flag 0, bus_err 0.
REQ-026 Reset mid-transaction drops it silently; no completion pulse; late mem_rvalid afterwards ignored.
REQ-027 bus_err clears only on reset.

Structure
REQ-028 Package mem_arb_pkg holds state enum, owner enum (OWN_FETCH, OWN_DATA), default TIMEOUT_CYC.
REQ-029 One sub-module mem_arb_timeout: counter with clear, enable, expired output.

Verification
REQ-030 Read fetch 0x0000_0040, mem_gnt immediate, mem_rvalid next cycle data 0x0000_0013 -> if_rvalid cycle 3, if_rdata 0x0000_0013.
REQ-031 if_req and d_req (load 0x1000) same cycle -> data first, d_done before fetch starts; stall_if high throughout.
REQ-032 Store 0x2000 data 0xA5A5_A5A5 be 0xF, mem_gnt held low 5 cycles -> mem_* stable, d_done one cycle after gnt, no RESP.
REQ-033 Fetch in RESP, if_kill pulsed -> mem_rvalid consumed, if_rvalid never asserts, next fetch proceeds.
REQ-034 No mem_gnt for 64 cycles -> bus_err=1, completion pulse with rdata 0, FSM IDLE.
REQ-035 reset asserted in RESP, mem_rvalid arrives after -> no pulses, all outputs 0.
